// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch (128-bit line) and load/store requests onto one byte-serial memory controller.
// One single-cycle command per transaction; ack pulses one cycle after the controller drops busy; rdy=0 freezes everything.
module mem_req_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         if_req,
  input  logic [31:0]  if_addr,
  input  logic         if_flush,
  output logic         if_ack,
  output logic [127:0] if_data,
  input  logic         dm_re,
  input  logic         dm_we,
  input  logic [31:0]  dm_addr,
  input  logic [2:0]   dm_width,
  input  logic [31:0]  dm_wdata,
  output logic         dm_ack,
  output logic [31:0]  dm_rdata,
  output logic         ctrl_inst_re,
  output logic [31:0]  ctrl_inst_addr,
  output logic         ctrl_mem_re,
  output logic         ctrl_mem_we,
  output logic [31:0]  ctrl_mem_addr,
  output logic [2:0]   ctrl_mem_width,
  output logic [31:0]  ctrl_mem_wdata,
  input  logic [127:0] ctrl_inst_data,
  input  logic         ctrl_inst_busy,
  input  logic [31:0]  ctrl_mem_rdata,
  input  logic         ctrl_mem_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_COOL      = 3'd4;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [2:0]       state_q, state_d;
  logic             is_fetch_q, is_fetch_d;
  logic             is_load_q, is_load_d;
  logic             discard_q, discard_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ctrl_inst_re_q, ctrl_inst_re_d;
  logic [31:0]      ctrl_inst_addr_q, ctrl_inst_addr_d;
  logic             ctrl_mem_re_q, ctrl_mem_re_d;
  logic             ctrl_mem_we_q, ctrl_mem_we_d;
  logic [31:0]      ctrl_mem_addr_q, ctrl_mem_addr_d;
  logic [2:0]       ctrl_mem_width_q, ctrl_mem_width_d;
  logic [31:0]      ctrl_mem_wdata_q, ctrl_mem_wdata_d;
  logic             if_ack_q, if_ack_d;
  logic [127:0]     if_data_q, if_data_d;
  logic             dm_ack_q, dm_ack_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;

  logic fetch_vld, data_vld, force_fetch, grant_data, grant_fetch, busy_match;

  // A fetch raised together with a flush is treated as absent for this cycle.
  assign fetch_vld   = if_req & ~if_flush;
  assign data_vld    = dm_re | dm_we;
  assign force_fetch = fetch_vld & (cnt_q == LIMIT);
  assign grant_data  = (state_q == S_IDLE) & data_vld & ~force_fetch;
  assign grant_fetch = (state_q == S_IDLE) & fetch_vld & ~grant_data;
  assign busy_match  = is_fetch_q ? ctrl_inst_busy : ctrl_mem_busy;

  always_comb begin
    state_d          = state_q;
    is_fetch_d       = is_fetch_q;
    is_load_d        = is_load_q;
    discard_d        = discard_q;
    cnt_d            = cnt_q;
    ctrl_inst_re_d   = ctrl_inst_re_q;
    ctrl_inst_addr_d = ctrl_inst_addr_q;
    ctrl_mem_re_d    = ctrl_mem_re_q;
    ctrl_mem_we_d    = ctrl_mem_we_q;
    ctrl_mem_addr_d  = ctrl_mem_addr_q;
    ctrl_mem_width_d = ctrl_mem_width_q;
    ctrl_mem_wdata_d = ctrl_mem_wdata_q;
    if_ack_d         = 1'b0;
    if_data_d        = if_data_q;
    dm_ack_d         = 1'b0;
    dm_rdata_d       = dm_rdata_q;

    if ((state_q != S_IDLE) && is_fetch_q && if_flush) begin
      discard_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        discard_d = 1'b0;
        if (!if_req || grant_fetch) begin
          cnt_d = '0;
        end else if (grant_data && fetch_vld && (cnt_q != LIMIT)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (grant_data) begin
          // dm_re together with dm_we is illegal; the store wins.
          is_fetch_d       = 1'b0;
          is_load_d        = dm_re & ~dm_we;
          ctrl_mem_re_d    = dm_re & ~dm_we;
          ctrl_mem_we_d    = dm_we;
          ctrl_mem_addr_d  = dm_addr;
          ctrl_mem_width_d = dm_width;
          ctrl_mem_wdata_d = dm_wdata;
          state_d          = S_ISSUE;
        end else if (grant_fetch) begin
          is_fetch_d       = 1'b1;
          is_load_d        = 1'b0;
          ctrl_inst_re_d   = 1'b1;
          ctrl_inst_addr_d = if_addr;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ctrl_inst_re_d = 1'b0;
        ctrl_mem_re_d  = 1'b0;
        ctrl_mem_we_d  = 1'b0;
        state_d        = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy_match) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!busy_match) begin
          if (is_fetch_q) begin
            if (!(discard_q || if_flush)) begin
              if_data_d = ctrl_inst_data;
              if_ack_d  = 1'b1;
            end
          end else begin
            if (is_load_q) begin
              dm_rdata_d = ctrl_mem_rdata;
            end
            dm_ack_d = 1'b1;
          end
          state_d = S_COOL;
        end
      end
      S_COOL: begin
        discard_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      is_fetch_q       <= 1'b0;
      is_load_q        <= 1'b0;
      discard_q        <= 1'b0;
      cnt_q            <= '0;
      ctrl_inst_re_q   <= 1'b0;
      ctrl_inst_addr_q <= '0;
      ctrl_mem_re_q    <= 1'b0;
      ctrl_mem_we_q    <= 1'b0;
      ctrl_mem_addr_q  <= '0;
      ctrl_mem_width_q <= '0;
      ctrl_mem_wdata_q <= '0;
      if_ack_q         <= 1'b0;
      if_data_q        <= '0;
      dm_ack_q         <= 1'b0;
      dm_rdata_q       <= '0;
    end else if (rdy) begin
      state_q          <= state_d;
      is_fetch_q       <= is_fetch_d;
      is_load_q        <= is_load_d;
      discard_q        <= discard_d;
      cnt_q            <= cnt_d;
      ctrl_inst_re_q   <= ctrl_inst_re_d;
      ctrl_inst_addr_q <= ctrl_inst_addr_d;
      ctrl_mem_re_q    <= ctrl_mem_re_d;
      ctrl_mem_we_q    <= ctrl_mem_we_d;
      ctrl_mem_addr_q  <= ctrl_mem_addr_d;
      ctrl_mem_width_q <= ctrl_mem_width_d;
      ctrl_mem_wdata_q <= ctrl_mem_wdata_d;
      if_ack_q         <= if_ack_d;
      if_data_q        <= if_data_d;
      dm_ack_q         <= dm_ack_d;
      dm_rdata_q       <= dm_rdata_d;
    end
  end

  assign ctrl_inst_re   = ctrl_inst_re_q;
  assign ctrl_inst_addr = ctrl_inst_addr_q;
  assign ctrl_mem_re    = ctrl_mem_re_q;
  assign ctrl_mem_we    = ctrl_mem_we_q;
  assign ctrl_mem_addr  = ctrl_mem_addr_q;
  assign ctrl_mem_width = ctrl_mem_width_q;
  assign ctrl_mem_wdata = ctrl_mem_wdata_q;
  assign if_ack         = if_ack_q;
  assign if_data        = if_data_q;
  assign dm_ack         = dm_ack_q;
  assign dm_rdata       = dm_rdata_q;

endmodule
